// File: rtl/wm8978_i2c_slave_pkg.sv
// Shared types for the WM8978-format I2C write target: FSM state encoding and
// the register-word field widths.
package wm8978_i2c_slave_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEV  = 3'd1,
    ST_DACK = 3'd2,
    ST_HI   = 3'd3,
    ST_HACK = 3'd4,
    ST_LO   = 3'd5,
    ST_LACK = 3'd6,
    ST_SKIP = 3'd7
  } i2c_state_t;

endpackage

// File: rtl/wm8978_i2c_slave_i2c_line_filter.sv
// One I2C line: 2-flop synchronizer, FILT_LEN-cycle glitch filter and edge
// detection of the filtered level. Idle bus level is high.
module wm8978_i2c_slave_i2c_line_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [2:0] CNT_INIT = 3'(FILT_LEN - 1);

  logic [1:0] sync;
  logic [2:0] cnt;
  logic       level_d;

  // Down-counter reloads whenever the synchronized input agrees with the
  // accepted level; it must reach zero on a run of consecutive disagreements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= CNT_INIT;
    end else begin
      sync    <= {sync[0], line};
      level_d <= level;
      if (sync[1] == level) begin
        cnt <= CNT_INIT;
      end else if (cnt == 3'd0) begin
        level <= sync[1];
        cnt   <= CNT_INIT;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/wm8978_i2c_slave.sv
// I2C write-only target for WM8978-style 16-bit register words; each word is
// presented on a one-cycle wr_en strobe.
//
// state | meaning
// IDLE  | bus free or not addressed
// DEV   | shifting in device byte
// DACK  | ACK slot after device byte (drive low between the two SCL falls)
// HI    | shifting in high byte {addr[6:0], data[8]}
// HACK  | ACK slot after high byte
// LO    | shifting in low byte data[7:0]
// LACK  | ACK slot after low byte, then back to HI for the next word
// SKIP  | not addressed: ignore bits until START/STOP
module wm8978_i2c_slave
  import wm8978_i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h1a,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              nack_evt
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  wm8978_i2c_slave_i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  wm8978_i2c_slave_i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_state_t state, state_nxt;
  logic       ack_on, ack_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] hi_byte;
  logic       wr_pend;

  logic       start_c, stop_c, in_data, byte_done, addr_ok;
  logic [7:0] byte_val;

  assign start_c   = sda_fall & scl_lvl;
  assign stop_c    = sda_rise & scl_lvl;
  assign in_data   = (state == ST_DEV) || (state == ST_HI) || (state == ST_LO);
  assign byte_done = in_data && scl_rise && (bit_cnt == 3'd7);
  assign byte_val  = {shift[6:0], sda_lvl};
  assign addr_ok   = (byte_val[7:1] == SLAVE_ADDR) && !byte_val[0];

  assign sda = ack_on ? 1'b0 : 1'bz;

  always_comb begin
    state_nxt = state;
    ack_nxt   = ack_on;
    if (start_c) begin
      state_nxt = ST_DEV;
      ack_nxt   = 1'b0;
    end else if (stop_c) begin
      state_nxt = ST_IDLE;
      ack_nxt   = 1'b0;
    end else begin
      case (state)
        ST_DEV:  if (byte_done) state_nxt = addr_ok ? ST_DACK : ST_SKIP;
        ST_HI:   if (byte_done) state_nxt = ST_HACK;
        ST_LO:   if (byte_done) state_nxt = ST_LACK;
        ST_DACK, ST_HACK, ST_LACK: begin
          // first SCL fall starts the ACK bit, second one ends it
          if (scl_fall) begin
            if (!ack_on) begin
              ack_nxt = 1'b1;
            end else begin
              ack_nxt   = 1'b0;
              state_nxt = (state == ST_HACK) ? ST_LO : ST_HI;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ack_on   <= 1'b0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      hi_byte  <= 8'h00;
      wr_pend  <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      nack_evt <= 1'b0;
    end else begin
      state    <= state_nxt;
      ack_on   <= ack_nxt;
      wr_en    <= wr_pend;
      wr_pend  <= 1'b0;
      nack_evt <= 1'b0;
      if (start_c || stop_c) begin
        bit_cnt <= 3'd0;
        if (stop_c) busy <= 1'b0;
      end else if (in_data && scl_rise) begin
        shift   <= byte_val;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          case (state)
            ST_DEV: begin
              busy     <= addr_ok;
              nack_evt <= !addr_ok;
            end
            ST_HI: hi_byte <= byte_val;
            ST_LO: begin
              wr_addr <= hi_byte[7:1];
              wr_data <= {hi_byte[0], byte_val};
              wr_pend <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_wm8978_i2c_slave.sv
// Directed bench: a bit-banged 250 kHz I2C master drives the target and a
// negedge monitor logs write strobes, NACK pulses and bus activity.
module tb_wm8978_i2c_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_oe;
  wire        sda;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       nack_evt;

  always #10 clk = ~clk;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  wm8978_i2c_slave #(.SLAVE_ADDR(7'h1a), .FILT_LEN(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .nack_evt (nack_evt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // bus monitor
  int         n_wr, n_nack;
  logic       busy_seen, low_seen;
  logic [6:0] log_a [8];
  logic [8:0] log_d [8];

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (n_wr < 8) begin
          log_a[n_wr] = wr_addr;
          log_d[n_wr] = wr_data;
        end
        n_wr++;
      end
      if (nack_evt) n_nack++;
      if (busy) busy_seen = 1'b1;
      if (!m_oe && sda === 1'b0) low_seen = 1'b1;
    end
  end

  task automatic clr();
    n_wr = 0; n_nack = 0; busy_seen = 1'b0; low_seen = 1'b0;
  endtask

  task automatic q();
    repeat (50) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; q(); scl = 1'b1; q();
    m_oe = 1'b1; q(); scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; q(); scl = 1'b1; q();
    m_oe = 1'b0; q();
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask

  task automatic get_ack(output logic ack);
    m_oe = 1'b0; q(); scl = 1'b1; q();
    ack = (sda === 1'b0);
    q(); scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(ack);
  endtask

  logic ack;
  logic [7:0] bv;

  initial begin
    rst_n = 1'b0; scl = 1'b1; m_oe = 1'b0;
    clr();
    repeat (5) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nack", 32'(nack_evt), 32'd0);
    chk("rst_sda", 32'(sda), 32'd1);
    rst_n = 1'b1;
    q();

    // single word
    clr();
    i2c_start();
    send_byte(8'h34, ack); chk("t1_ack_dev", 32'(ack), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h02, ack); chk("t1_ack_hi", 32'(ack), 32'd1);
    send_byte(8'h1B, ack); chk("t1_ack_lo", 32'(ack), 32'd1);
    i2c_stop(); q();
    chk("t1_n_wr", 32'(n_wr), 32'd1);
    chk("t1_addr", 32'(log_a[0]), 32'h01);
    chk("t1_data", 32'(log_d[0]), 32'h01B);
    chk("t1_busy_stop", 32'(busy), 32'd0);
    chk("t1_hold_addr", 32'(wr_addr), 32'h01);

    // two back-to-back words
    clr();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h0E, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h10, ack); chk("t2_ack_hi2", 32'(ack), 32'd1);
    send_byte(8'h80, ack); chk("t2_ack_lo2", 32'(ack), 32'd1);
    i2c_stop(); q();
    chk("t2_n_wr", 32'(n_wr), 32'd2);
    chk("t2_addr0", 32'(log_a[0]), 32'h07);
    chk("t2_data0", 32'(log_d[0]), 32'h0FF);
    chk("t2_addr1", 32'(log_a[1]), 32'h08);
    chk("t2_data1", 32'(log_d[1]), 32'h080);

    // wrong address, then read request
    clr();
    i2c_start();
    send_byte(8'h36, ack); chk("t3_nack_wrong", 32'(ack), 32'd0);
    i2c_stop(); q();
    i2c_start();
    send_byte(8'h35, ack); chk("t3_nack_read", 32'(ack), 32'd0);
    i2c_stop(); q();
    chk("t3_n_nack", 32'(n_nack), 32'd2);
    chk("t3_n_wr", 32'(n_wr), 32'd0);
    chk("t3_busy_seen", 32'(busy_seen), 32'd0);
    chk("t3_sda_low", 32'(low_seen), 32'd0);

    // partial word cut by STOP, then a full word
    clr();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h02, ack);
    bv = 8'hA5;
    for (int i = 7; i >= 4; i--) send_bit(bv[i]);
    i2c_stop(); q();
    chk("t4_n_wr_cut", 32'(n_wr), 32'd0);
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h04, ack);
    send_byte(8'h01, ack);
    i2c_stop(); q();
    chk("t4_n_wr", 32'(n_wr), 32'd1);
    chk("t4_addr", 32'(log_a[0]), 32'h02);
    chk("t4_data", 32'(log_d[0]), 32'h001);

    // repeated START after the high byte
    clr();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte(8'h34, ack); chk("t5_ack_dev", 32'(ack), 32'd1);
    send_byte(8'h03, ack);
    send_byte(8'h3F, ack);
    i2c_stop(); q();
    chk("t5_n_wr", 32'(n_wr), 32'd1);
    chk("t5_addr", 32'(log_a[0]), 32'h01);
    chk("t5_data", 32'(log_d[0]), 32'h13F);

    // reset while the target is driving ACK
    clr();
    i2c_start();
    bv = 8'h34;
    for (int i = 7; i >= 0; i--) send_bit(bv[i]);
    m_oe = 1'b0; q(); scl = 1'b1; q();
    chk("t6_sda_pre", 32'(sda), 32'd0);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_sda_rel", 32'(sda), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_wr_addr", 32'(wr_addr), 32'd0);
    chk("t6_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    q(); scl = 1'b0; q();
    i2c_stop(); q();

    // full write with a 2-cycle SCL glitch inside the high byte
    clr();
    i2c_start();
    send_byte(8'h34, ack); chk("t7_ack_dev", 32'(ack), 32'd1);
    bv = 8'h02;
    for (int i = 7; i >= 4; i--) send_bit(bv[i]);
    scl = 1'b1; @(negedge clk); @(negedge clk); scl = 1'b0; q();
    for (int i = 3; i >= 0; i--) send_bit(bv[i]);
    get_ack(ack); chk("t7_ack_hi", 32'(ack), 32'd1);
    send_byte(8'h1B, ack); chk("t7_ack_lo", 32'(ack), 32'd1);
    i2c_stop(); q();
    chk("t7_n_wr", 32'(n_wr), 32'd1);
    chk("t7_addr", 32'(log_a[0]), 32'h01);
    chk("t7_data", 32'(log_d[0]), 32'h01B);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
